conv_window_mac: RTL and testbench

Downstream consumer of the convolution accelerator's input memory: sequences the 3x3 window read offsets (`mul_shift`, `accu_shift`) over a 5x5 input tile, multiplies each returned 32-bit pixel by the matching kernel weight and accumulates nine products per window. It emits nine output pixels (3x3 valid-convolution result) over a valid/ready handshake toward the output stage. It never writes the input memory; loading the tile completes before `start`.

---
 rtl/conv_window_mac_if.sv | 31 +++
 rtl/conv_window_mac.sv | 133 +++++++++++++
 tb/tb_conv_window_mac.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_mac_if.sv
// Memory-read and result-handshake bundle for conv_window_mac.
// master: the MAC engine side; slave: input memory / weight ROM / output stage side.
interface conv_window_mac_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32
) ();
  logic                  mem_en;
  logic [3:0]            mul_shift;
  logic [3:0]            accu_shift;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [3:0]            weight_idx;
  logic [DATA_WIDTH-1:0] weight_data;
  logic [ACC_WIDTH-1:0]  result;
  logic [3:0]            result_idx;
  logic                  result_valid;
  logic                  result_ready;

  modport master (
    output mem_en, mul_shift, accu_shift, weight_idx,
    input  mem_data, weight_data,
    output result, result_idx, result_valid,
    input  result_ready
  );

  modport slave (
    input  mem_en, mul_shift, accu_shift, weight_idx,
    output mem_data, weight_data,
    input  result, result_idx, result_valid,
    output result_ready
  );
endinterface

// File: rtl/conv_window_mac.sv
// 3x3 valid convolution over a 5x5 tile: walks window offsets, MACs nine products per window.
// Define CONV_RELU_EN to clamp negative window sums to zero.
module conv_window_mac #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  conv_window_mac_if.master bus
);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StOutput, StDone} state_e;

  state_e                       state_q, state_d;
  logic [3:0]                   j_q, j_d, k_q, k_d;
  logic                         mac_vld_q, mac_first_q;
  logic [ACC_WIDTH-1:0]         acc_q, acc_d, result_q, result_d, sum;
  logic signed [ACC_WIDTH-1:0]  pix_ext, wgt_ext, prod;

  // Row-major offsets of a 3x3 window inside a 5-wide tile.
  function automatic logic [3:0] ofs(input logic [3:0] i);
    case (i)
      4'd0:    return 4'd0;
      4'd1:    return 4'd1;
      4'd2:    return 4'd2;
      4'd3:    return 4'd5;
      4'd4:    return 4'd6;
      4'd5:    return 4'd7;
      4'd6:    return 4'd10;
      4'd7:    return 4'd11;
      4'd8:    return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  always_comb begin
    state_d          = state_q;
    j_d              = j_q;
    k_d              = k_q;
    bus.mem_en       = 1'b0;
    bus.mul_shift    = 4'd0;
    bus.accu_shift   = 4'd0;
    bus.weight_idx   = 4'd0;
    bus.result       = '0;
    bus.result_idx   = 4'd0;
    bus.result_valid = 1'b0;
    busy             = (state_q != StIdle);
    done             = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          j_d     = 4'd0;
          k_d     = 4'd0;
        end
      end
      StFetch: begin
        bus.mem_en     = 1'b1;
        bus.mul_shift  = ofs(k_q);
        bus.accu_shift = ofs(j_q);
        bus.weight_idx = k_q;
        if (k_q == 4'd8) begin
          state_d = StDrain;
          k_d     = 4'd0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StDrain: state_d = StOutput;
      StOutput: begin
        bus.result_valid = 1'b1;
        bus.result       = result_q;
        bus.result_idx   = j_q;
        if (bus.result_ready) begin
          if (j_q == 4'd8) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
            j_d     = j_q + 4'd1;
            k_d     = 4'd0;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
        j_d     = 4'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Low ACC_WIDTH bits of the signed product equal the product of the sign-extended operands.
  always_comb begin
    pix_ext  = ACC_WIDTH'($signed(bus.mem_data));
    wgt_ext  = ACC_WIDTH'($signed(bus.weight_data));
    prod     = pix_ext * wgt_ext;
    sum      = (mac_first_q ? '0 : acc_q) + prod;
    acc_d    = mac_vld_q ? sum : acc_q;
    result_d = result_q;
    if (state_q == StDrain) begin
`ifdef CONV_RELU_EN
      result_d = sum[ACC_WIDTH-1] ? '0 : sum;
`else
      result_d = sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      j_q         <= 4'd0;
      k_q         <= 4'd0;
      acc_q       <= '0;
      result_q    <= '0;
      mac_vld_q   <= 1'b0;
      mac_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      mac_vld_q   <= (state_q == StFetch);
      mac_first_q <= (state_q == StFetch) && (k_q == 4'd0);
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac: tile memory and weight ROM models, expected sums queued at start.
module tb_conv_window_mac;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic [AW-1:0] val;
    logic [3:0]    idx;
  } exp_t;

  logic clk_tb;
  logic rst;
  logic start;
  logic busy;
  logic done;

  conv_window_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  conv_window_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk   (clk_tb),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  logic signed [DW-1:0] tile [25];
  logic signed [DW-1:0] wts  [9];
  int                   ofs_t [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  exp_t                 exp_q [$];
  int                   n_cmp = 0;
  int                   n_fail = 0;

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // Registered input memory and weight ROM.
  always @(posedge clk_tb) begin
    if (bus.mem_en && (int'(bus.mul_shift) + int'(bus.accu_shift) < 25))
      bus.mem_data <= tile[int'(bus.mul_shift) + int'(bus.accu_shift)];
    if (int'(bus.weight_idx) < 9) bus.weight_data <= wts[bus.weight_idx];
    else bus.weight_data <= '0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void set_pixels();
    for (int i = 0; i < 25; i++) tile[i] = DW'(i);
  endfunction

  function automatic void set_weights(input int v);
    for (int i = 0; i < 9; i++) wts[i] = DW'(v);
  endfunction

  function automatic void push_expected();
    for (int j = 0; j < 9; j++) begin
      logic [AW-1:0] s;
      exp_t          e;
      s = '0;
      for (int k = 0; k < 9; k++) s = s + AW'(tile[ofs_t[j] + ofs_t[k]] * wts[k]);
`ifdef CONV_RELU_EN
      if (s[AW-1]) s = '0;
`endif
      e.val = s;
      e.idx = 4'(j);
      exp_q.push_back(e);
    end
  endfunction

  // Runs one tile from a start pulse; stall_n cycles of backpressure on the first result.
  task automatic run_tile(input int stall_n, output int first_valid, output int done_cyc,
                          output int mem_cnt, output int acc_cyc, output int w1_cyc,
                          output int max_sum);
    int   stall_left;
    exp_t e;
    first_valid = -1;
    done_cyc    = -1;
    mem_cnt     = 0;
    acc_cyc     = -1;
    w1_cyc      = -1;
    max_sum     = 0;
    stall_left  = stall_n;
    @(negedge clk_tb);
    start = 1'b1;
    bus.result_ready = (stall_n == 0);
    for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
      @(negedge clk_tb);
      start = 1'b0;
      if (bus.mem_en) begin
        mem_cnt++;
        if (int'(bus.mul_shift) + int'(bus.accu_shift) > max_sum)
          max_sum = int'(bus.mul_shift) + int'(bus.accu_shift);
        if (w1_cyc < 0 && bus.accu_shift == 4'd1) w1_cyc = c;
      end
      if (done) done_cyc = c;
      if (bus.result_valid) begin
        if (first_valid < 0) first_valid = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got %0d idx %0d, no result expected",
                   $signed(bus.result), bus.result_idx);
          bus.result_ready = 1'b1;
        end else if (stall_left > 0) begin
          if (bus.result !== exp_q[0].val || bus.result_idx !== exp_q[0].idx
              || bus.mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d idx %0d mem_en %0b, expected %0d idx %0d mem_en 0",
                     $signed(bus.result), bus.result_idx, bus.mem_en,
                     $signed(exp_q[0].val), exp_q[0].idx);
          end
          stall_left--;
        end else begin
          e = exp_q.pop_front();
          if (bus.result !== e.val || bus.result_idx !== e.idx) begin
            n_fail++;
            $display("FAIL result: got %0d idx %0d, expected %0d idx %0d",
                     $signed(bus.result), bus.result_idx, $signed(e.val), e.idx);
          end
          if (acc_cyc < 0) acc_cyc = c;
          bus.result_ready = 1'b1;
        end
      end
    end
    n_cmp++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, expected one within 400 cycles");
    end
    @(negedge clk_tb);
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL end_idle: got busy %0b pending %0d, expected busy 0 pending 0",
               busy, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.result_ready = 1'b1;
    repeat (3) @(negedge clk_tb);
    n_cmp++;
    if ({bus.mem_en, bus.mul_shift, bus.accu_shift, bus.weight_idx, bus.result, bus.result_idx,
         bus.result_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got mem_en %0b busy %0b valid %0b result %0d, expected all 0",
               bus.mem_en, busy, bus.result_valid, bus.result);
    end
    rst = 1'b0;
    @(negedge clk_tb);
    n_cmp++;
    if ({bus.mem_en, bus.result_valid, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got mem_en %0b valid %0b busy %0b done %0b, expected 0",
               bus.mem_en, bus.result_valid, busy, done);
    end
  endtask

  task automatic test_address_seq();
    set_pixels();
    set_weights(1);
    @(negedge clk_tb);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_tb);
      start = 1'b0;
      n_cmp++;
      if (bus.mem_en !== 1'b1 || int'(bus.mul_shift) != ofs_t[c-1] || bus.accu_shift !== 4'd0
          || int'(bus.weight_idx) != c - 1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL addr_k%0d: got en %0b mul %0d accu %0d widx %0d, expected 1 %0d 0 %0d",
                 c - 1, bus.mem_en, bus.mul_shift, bus.accu_shift, bus.weight_idx,
                 ofs_t[c-1], c - 1);
      end
    end
    @(negedge clk_tb);
    n_cmp++;
    if (bus.mem_en !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got mem_en %0b valid %0b, expected 0 0", bus.mem_en, bus.result_valid);
    end
    @(negedge clk_tb);
    n_cmp++;
    if (bus.result_valid !== 1'b1 || bus.result !== 32'd54 || bus.result_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL first_result: got valid %0b %0d idx %0d, expected 1 54 0",
               bus.result_valid, bus.result, bus.result_idx);
    end
    @(negedge clk_tb);
    n_cmp++;
    if (bus.mem_en !== 1'b1 || bus.mul_shift !== 4'd0 || bus.accu_shift !== 4'd1) begin
      n_fail++;
      $display("FAIL window1_addr: got en %0b mul %0d accu %0d, expected 1 0 1",
               bus.mem_en, bus.mul_shift, bus.accu_shift);
    end
    rst = 1'b1;
    @(negedge clk_tb);
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    int fv, dc, mc, ac, w1, ms;
    set_pixels();
    set_weights(1);
    push_expected();
    run_tile(0, fv, dc, mc, ac, w1, ms);
    n_cmp++;
    if (fv != 11 || dc != 100) begin
      n_fail++;
      $display("FAIL ones_timing: got first valid %0d done %0d, expected 11 100", fv, dc);
    end
    n_cmp++;
    if (mc != 81 || ms > 24) begin
      n_fail++;
      $display("FAIL ones_reads: got %0d mem_en cycles max offset %0d, expected 81 and <=24",
               mc, ms);
    end
  endtask

  task automatic test_identity();
    int fv, dc, mc, ac, w1, ms;
    set_pixels();
    set_weights(0);
    wts[4] = 32'sd1;
    push_expected();
    run_tile(0, fv, dc, mc, ac, w1, ms);
    n_cmp++;
    if (fv != 11 || mc != 81) begin
      n_fail++;
      $display("FAIL identity_timing: got first valid %0d reads %0d, expected 11 81", fv, mc);
    end
  endtask

  task automatic test_back_pressure();
    int fv, dc, mc, ac, w1, ms;
    set_pixels();
    set_weights(1);
    push_expected();
    run_tile(5, fv, dc, mc, ac, w1, ms);
    n_cmp++;
    if (fv != 11 || ac != 16 || w1 != 17) begin
      n_fail++;
      $display("FAIL backpressure_timing: got valid %0d accept %0d w1 fetch %0d, expected 11 16 17",
               fv, ac, w1);
    end
    n_cmp++;
    if (mc != 81 || dc != 105) begin
      n_fail++;
      $display("FAIL backpressure_totals: got reads %0d done %0d, expected 81 105", mc, dc);
    end
  endtask

  task automatic test_reset_mid_run();
    int fv, dc, mc, ac, w1, ms;
    int bad;
    set_pixels();
    set_weights(1);
    bus.result_ready = 1'b1;
    @(negedge clk_tb);
    start = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      int w, p, e_mul, e_acc;
      logic e_en;
      @(negedge clk_tb);
      start = (c == 5);
      w = (c - 1) / 11;
      p = (c - 1) % 11;
      e_en  = (p < 9);
      e_mul = (p < 9) ? ofs_t[p] : 0;
      e_acc = (p < 9) ? ofs_t[w] : 0;
      n_cmp++;
      if (bus.mem_en !== e_en || int'(bus.mul_shift) != e_mul || int'(bus.accu_shift) != e_acc) begin
        n_fail++;
        $display("FAIL midrun_c%0d: got en %0b mul %0d accu %0d, expected %0b %0d %0d",
                 c, bus.mem_en, bus.mul_shift, bus.accu_shift, e_en, e_mul, e_acc);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk_tb);
    rst = 1'b0;
    n_cmp++;
    if ({bus.mem_en, bus.mul_shift, bus.accu_shift, bus.weight_idx, bus.result, bus.result_idx,
         bus.result_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got en %0b busy %0b valid %0b result %0d, expected all 0",
               bus.mem_en, busy, bus.result_valid, bus.result);
    end
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_tb);
      if (bus.mem_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d active cycles, expected 0", bad);
    end
    push_expected();
    run_tile(0, fv, dc, mc, ac, w1, ms);
    n_cmp++;
    if (fv != 11 || dc != 100) begin
      n_fail++;
      $display("FAIL restart_timing: got first valid %0d done %0d, expected 11 100", fv, dc);
    end
  endtask

  task automatic test_negative_weights();
    int fv, dc, mc, ac, w1, ms;
    set_pixels();
    set_weights(-1);
    push_expected();
    run_tile(0, fv, dc, mc, ac, w1, ms);
    n_cmp++;
    if (dc != 100) begin
      n_fail++;
      $display("FAIL negative_done: got done %0d, expected 100", dc);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.result_ready = 1'b1;
    set_pixels();
    set_weights(1);
    test_reset();
    test_address_seq();
    test_all_ones();
    test_identity();
    test_back_pressure();
    test_reset_mid_run();
    test_negative_weights();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
